// File: rtl/cla_pipe_adder.sv
// Two-stage pipelined carry-lookahead adder/subtractor with valid/ready on both ends.
// Build option: define ADDER_FLAGS_EN to compute carry/overflow/zero; otherwise they are tied to 0.

`ifndef GROUPSIZE
`define GROUPSIZE 4
`endif

module cla_pipe_adder #(
  parameter int WIDTH     = 32,
  parameter int GROUPSIZE = `GROUPSIZE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow,
  output logic             zero
);

  localparam int N = WIDTH / GROUPSIZE;

  if ((WIDTH % GROUPSIZE) != 0) begin : g_bad_width
    $error("cla_pipe_adder: WIDTH must be a multiple of GROUPSIZE");
  end
  if (!(GROUPSIZE == 1 || GROUPSIZE == 2 || GROUPSIZE == 4 || GROUPSIZE == 8)) begin : g_bad_group
    $error("cla_pipe_adder: GROUPSIZE must be 1, 2, 4 or 8");
  end

  // Handshake contract: a beat moves across a boundary on a rising edge where
  // valid & ready are both high; the sender holds data stable until then, and
  // rst blocks every transfer in the cycle it is high.
  logic s2_ready;
  logic accept;
  logic s1_fire;

  // Stage 1 registers
  logic                            s1_valid_q, s1_valid_d;
  logic [N-1:0][GROUPSIZE-1:0]     s1_sum0_q,  s1_sum0_d;
  logic [N-1:0][GROUPSIZE-1:0]     s1_sum1_q,  s1_sum1_d;
  logic [N-1:0]                    s1_g_q,     s1_g_d;
  logic [N-1:0]                    s1_p_q,     s1_p_d;
  logic                            s1_cin_q,   s1_cin_d;

  // Stage 2 (output) registers
  logic                            out_valid_q, out_valid_d;
  logic [WIDTH-1:0]                result_q,    result_d;

  // Operand prep and per-group lookahead terms
  logic [WIDTH-1:0]                b_eff;
  logic                            c_in;
  logic [WIDTH-1:0]                bit_g;
  logic [WIDTH-1:0]                bit_p;
  logic [N-1:0][GROUPSIZE-1:0]     grp_sum0;
  logic [N-1:0][GROUPSIZE-1:0]     grp_sum1;
  logic [N-1:0]                    grp_g;
  logic [N-1:0]                    grp_p;

  // Stage 2 carry resolution
  logic [N-1:0]                    grp_c;
  logic [WIDTH-1:0]                res_sum;

  assign s2_ready  = ~out_valid_q | out_ready;
  assign in_ready  = ~rst & (~s1_valid_q | s2_ready);
  assign accept    = in_valid & in_ready;
  assign s1_fire   = s1_valid_q & s2_ready;
  assign out_valid = out_valid_q & ~rst;
  assign result    = result_q;

  always_comb begin
    b_eff = sub ? ~b : b;
    c_in  = sub | cin;
    bit_g = a & b_eff;
    bit_p = a ^ b_eff;
  end

  // Each group ripples internally twice (carry-in 0 and 1) so stage 2 only selects.
  always_comb begin
    logic c0;
    logic c1;
    logic g_acc;
    logic p_acc;
    grp_sum0 = '0;
    grp_sum1 = '0;
    grp_g    = '0;
    grp_p    = '0;
    for (int k = 0; k < N; k++) begin
      c0    = 1'b0;
      c1    = 1'b1;
      g_acc = 1'b0;
      p_acc = 1'b1;
      for (int i = 0; i < GROUPSIZE; i++) begin
        grp_sum0[k][i] = bit_p[k*GROUPSIZE+i] ^ c0;
        grp_sum1[k][i] = bit_p[k*GROUPSIZE+i] ^ c1;
        c0    = bit_g[k*GROUPSIZE+i] | (bit_p[k*GROUPSIZE+i] & c0);
        c1    = bit_g[k*GROUPSIZE+i] | (bit_p[k*GROUPSIZE+i] & c1);
        g_acc = bit_g[k*GROUPSIZE+i] | (bit_p[k*GROUPSIZE+i] & g_acc);
        p_acc = p_acc & bit_p[k*GROUPSIZE+i];
      end
      grp_g[k] = g_acc;
      grp_p[k] = p_acc;
    end
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_sum0_d  = s1_sum0_q;
    s1_sum1_d  = s1_sum1_q;
    s1_g_d     = s1_g_q;
    s1_p_d     = s1_p_q;
    s1_cin_d   = s1_cin_q;
    if (accept) begin
      s1_valid_d = 1'b1;
      s1_sum0_d  = grp_sum0;
      s1_sum1_d  = grp_sum1;
      s1_g_d     = grp_g;
      s1_p_d     = grp_p;
      s1_cin_d   = c_in;
    end else if (s1_fire) begin
      s1_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_sum0_q  <= '0;
      s1_sum1_q  <= '0;
      s1_g_q     <= '0;
      s1_p_q     <= '0;
      s1_cin_q   <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_sum0_q  <= s1_sum0_d;
      s1_sum1_q  <= s1_sum1_d;
      s1_g_q     <= s1_g_d;
      s1_p_q     <= s1_p_d;
      s1_cin_q   <= s1_cin_d;
    end
  end

  // Inter-group carry chain over registered G/P, then per-group sum select.
  always_comb begin
    grp_c    = '0;
    grp_c[0] = s1_cin_q;
    for (int k = 0; k < N - 1; k++) begin
      grp_c[k+1] = s1_g_q[k] | (s1_p_q[k] & grp_c[k]);
    end
  end

  always_comb begin
    res_sum = '0;
    for (int k = 0; k < N; k++) begin
      res_sum[k*GROUPSIZE +: GROUPSIZE] = grp_c[k] ? s1_sum1_q[k] : s1_sum0_q[k];
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    result_d    = result_q;
    if (s2_ready) begin
      out_valid_d = s1_valid_q;
    end
    if (s1_fire) begin
      result_d = res_sum;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
    end
  end

`ifdef ADDER_FLAGS_EN
  logic s1_a_msb_q, s1_a_msb_d;
  logic s1_b_msb_q, s1_b_msb_d;
  logic carry_q,    carry_d;
  logic ovf_q,      ovf_d;
  logic zero_q,     zero_d;
  logic cout;

  assign cout = s1_g_q[N-1] | (s1_p_q[N-1] & grp_c[N-1]);

  always_comb begin
    s1_a_msb_d = s1_a_msb_q;
    s1_b_msb_d = s1_b_msb_q;
    carry_d    = carry_q;
    ovf_d      = ovf_q;
    zero_d     = zero_q;
    if (accept) begin
      s1_a_msb_d = a[WIDTH-1];
      s1_b_msb_d = b_eff[WIDTH-1];
    end
    if (s1_fire) begin
      carry_d = cout;
      ovf_d   = (s1_a_msb_q == s1_b_msb_q) & (res_sum[WIDTH-1] != s1_a_msb_q);
      zero_d  = ~|res_sum;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_a_msb_q <= 1'b0;
      s1_b_msb_q <= 1'b0;
      carry_q    <= 1'b0;
      ovf_q      <= 1'b0;
      zero_q     <= 1'b0;
    end else begin
      s1_a_msb_q <= s1_a_msb_d;
      s1_b_msb_q <= s1_b_msb_d;
      carry_q    <= carry_d;
      ovf_q      <= ovf_d;
      zero_q     <= zero_d;
    end
  end

  assign carry    = carry_q;
  assign overflow = ovf_q;
  assign zero     = zero_q;
`else
  assign carry    = 1'b0;
  assign overflow = 1'b0;
  assign zero     = 1'b0;
`endif

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Directed bench for cla_pipe_adder: reset, arithmetic corners, back-pressure,
// mid-flight reset, and a random stream checked against an arithmetic reference.

module tb_cla_pipe_adder;
  localparam int W = 32;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         sub;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         carry;
  logic         overflow;
  logic         zero;

  int compared   = 0;
  int mismatched = 0;

  // Expected entries are {overflow, carry, result}.
  logic [W+1:0] exp_q[$];

  cla_pipe_adder dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carry     (carry),
    .overflow  (overflow),
    .zero      (zero)
  );

  // Clock / watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // Driver / checker tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [W+1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                         input logic msub, input logic mcin);
    logic [W-1:0] be;
    logic         ci;
    logic [W:0]   s;
    logic         ov;
    be = msub ? ~mb : mb;
    ci = msub ? 1'b1 : mcin;
    s  = {1'b0, ma} + {1'b0, be} + {{W{1'b0}}, ci};
    ov = (ma[W-1] == be[W-1]) && (s[W-1] != ma[W-1]);
    return {ov, s};
  endfunction

  task automatic check_out(input string tag, input logic [W+1:0] e);
    check({tag, ".result"}, result, e[W-1:0]);
`ifdef ADDER_FLAGS_EN
    check({tag, ".carry"},    W'(carry),    W'(e[W]));
    check({tag, ".overflow"}, W'(overflow), W'(e[W+1]));
    check({tag, ".zero"},     W'(zero),     W'(e[W-1:0] == '0));
`else
    check({tag, ".carry"},    W'(carry),    '0);
    check({tag, ".overflow"}, W'(overflow), '0);
    check({tag, ".zero"},     W'(zero),     '0);
`endif
  endtask

  // One beat through an idle pipe with out_ready held high; checks 2-cycle latency.
  task automatic run_single(input string tag, input logic [W-1:0] va, input logic [W-1:0] vb,
                            input logic vsub, input logic vcin, input logic [W-1:0] exp_res,
                            input logic exp_c, input logic exp_v);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    a = va; b = vb; sub = vsub; cin = vcin;
    #1;
    check({tag, ".in_ready"}, W'(in_ready), 1);
    tick();
    in_valid = 1'b0;
    a = '0; b = '0; sub = 1'b0; cin = 1'b0;
    check({tag, ".lat1_valid"}, W'(out_valid), 0);
    tick();
    check({tag, ".lat2_valid"}, W'(out_valid), 1);
    check_out(tag, {exp_v, exp_c, exp_res});
    tick();
  endtask

  initial begin
    int accepted;
    int cycles;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; sub = 1'b0; cin = 1'b0;

    // Reset
    repeat (2) tick();
    rst = 1'b0;
    #1;
    check("reset.out_valid", W'(out_valid), 0);
    check("reset.in_ready",  W'(in_ready),  1);
    check_out("reset", '0);

    // Arithmetic corners with hand-computed results
    run_single("add_wrap",   32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
    run_single("sub_borrow", 32'h0000_0005, 32'h0000_0007, 1'b1, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0);
    run_single("add_ovf",    32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    run_single("carry_all",  32'h0FFF_FFFF, 32'h0000_0000, 1'b0, 1'b1, 32'h1000_0000, 1'b0, 1'b0);
    run_single("sub_cin_ign",32'h0000_0007, 32'h0000_0005, 1'b1, 1'b0, 32'h0000_0002, 1'b1, 1'b0);
    run_single("sub_ovf",    32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1);
    run_single("sub_zero",   32'h0000_0005, 32'h0000_0005, 1'b1, 1'b1, 32'h0000_0000, 1'b1, 1'b0);
    run_single("add_mixed",  32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 1'b1, 32'hACF1_3569, 1'b0, 1'b0);

    // Back-pressure: two beats held, third refused until out_ready rises
    out_ready = 1'b0;
    in_valid  = 1'b1; a = 32'd1; b = 32'd1; sub = 1'b0; cin = 1'b0;
    #1;
    check("bp.accept1", W'(in_ready), 1);
    tick();
    a = 32'd2; b = 32'd2;
    #1;
    check("bp.accept2", W'(in_ready), 1);
    tick();
    a = 32'd3; b = 32'd3;
    #1;
    check("bp.full_ready", W'(in_ready),  0);
    check("bp.full_valid", W'(out_valid), 1);
    check("bp.full_res",   result,        32'd2);
    tick();
    check("bp.hold_ready", W'(in_ready), 0);
    check("bp.hold_res",   result,       32'd2);
    out_ready = 1'b1;
    #1;
    check("bp.simul_ready", W'(in_ready), 1);
    check("bp.out0",        result,       32'd2);
    tick();
    in_valid = 1'b0;
    check("bp.out1_valid", W'(out_valid), 1);
    check("bp.out1",       result,        32'd4);
    tick();
    check("bp.out2_valid", W'(out_valid), 1);
    check("bp.out2",       result,        32'd6);
    tick();
    check("bp.drained", W'(out_valid), 0);

    // Reset with both stages occupied
    out_ready = 1'b0;
    in_valid  = 1'b1; a = 32'd10; b = 32'd10;
    tick();
    a = 32'd20; b = 32'd20;
    tick();
    in_valid = 1'b0;
    #1;
    check("midrst.full_ready", W'(in_ready),  0);
    check("midrst.full_valid", W'(out_valid), 1);
    rst = 1'b1; out_ready = 1'b1;
    #1;
    check("midrst.gate_valid", W'(out_valid), 0);
    check("midrst.gate_ready", W'(in_ready),  0);
    tick();
    rst = 1'b0;
    #1;
    check("midrst.after_valid", W'(out_valid), 0);
    check("midrst.after_ready", W'(in_ready),  1);
    check_out("midrst.after", '0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("midrst.no_stale", W'(out_valid), 0);
    end
    run_single("post_rst", 32'h0000_0100, 32'h0000_00FF, 1'b0, 1'b0, 32'h0000_01FF, 1'b0, 1'b0);

    // Random stream with random back-pressure against the arithmetic reference
    accepted = 0;
    cycles   = 0;
    while ((accepted < 10000 || exp_q.size() != 0) && cycles < 60000) begin
      out_ready = ($urandom_range(0, 3) != 0);
      in_valid  = (accepted < 10000) && ($urandom_range(0, 3) != 0);
      a   = $urandom;
      b   = $urandom;
      sub = 1'($urandom_range(0, 1));
      cin = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) a = 32'hFFFF_FFFF;
      if ($urandom_range(0, 7) == 0) b = 32'h0000_0000;
      #1;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("rand.spurious", W'(out_valid), 0);
        else check_out("rand", exp_q.pop_front());
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(a, b, sub, cin));
        accepted++;
      end
      @(posedge clk);
      #1;
      cycles++;
    end
    in_valid = 1'b0;
    check("rand.accepted", accepted, 10000);
    check("rand.drained",  exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/cla_pipe_adder.md
# cla_pipe_adder

Two-stage pipelined carry-lookahead adder/subtractor for the execute stage. Stage 1 builds per-group generate/propagate pairs and speculative group sums for carry-in 0 and 1. Stage 2 resolves the inter-group carry chain from the registered group GP pairs, selects each group's sum, and produces status flags. Both stages use valid/ready handshakes, so the unit sustains one operation per cycle under back-pressure.

## Interface
- WIDTH, 32, operand/result width; must be a multiple of GROUPSIZE
- GROUPSIZE, `GROUPSIZE (4), bits per lookahead group; legal values 1, 2, 4, 8
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operand beat valid
- in_ready  output  1  unit accepts a beat this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- sub  input  1  1: A − B (B inverted, carry-in forced to 1); 0: A + B + cin
- cin  input  1  carry-in; ignored when sub=1
- out_valid  output  1  result beat valid
- out_ready  input  1  consumer accepts result
- result  output  WIDTH  sum/difference, modulo 2^WIDTH
- carry  output  1  carry out of MSB (for sub: 1 = no borrow)
- overflow  output  1  signed overflow
- zero  output  1  result == 0

## Operation
- Operand prep: b_eff = sub ? ~b : b; c_in = sub ? 1 : cin.
- Stage 1 (on accept): for each group k of N = WIDTH/GROUPSIZE groups, register sum0[k] (group sum with carry-in 0), sum1[k] (with carry-in 1), G[k], P[k]. Also register c_in, a[MSB], and b_eff[MSB].
- Group GP: P[k] = AND of the group's bit propagates (a^b_eff); G[k] = the standard lookahead generate across the group, MSB-first priority.
- Stage 2: c[0] = c_in; c[k+1] = G[k] | (P[k] & c[k]); result group k = c[k] ? sum1[k] : sum0[k]; carry = c[N].
- overflow = (a[MSB] == b_eff[MSB]) & (result[MSB] != a[MSB]).
- zero = ~|result.
- Stage 2 registers result and flags. Output fields are stable while out_valid=1 and out_ready=0.
- Ordering is strict FIFO. No beat is dropped or duplicated.

## Timing
- Reset (registered, rst sampled high): s1_valid=0, out_valid=0; result, carry, overflow, zero, and all stage registers set to 0. in_ready is 1 in the cycle after reset.
- Handshakes:
  - in_ready = ~s1_valid | s2_ready
  - s2_ready = ~out_valid | out_ready
  - Input transfer when in_valid & in_ready; output transfer when out_valid & out_ready.
- Latency: a beat accepted in cycle t presents out_valid in cycle t+2 when not stalled. Throughput is 1 beat/cycle.
- Stall: with out_ready=0, up to 2 beats are held (one per stage). in_ready is combinational and deasserts once both stages are full.
- Simultaneous output transfer and new input with both stages full: allowed. Stage 1 advances to stage 2 and the new beat enters stage 1 in the same cycle.
- in_valid may drop without a transfer. a, b, sub, cin are only sampled on transfer.
- Reset mid-operation: rst has priority over every handshake. All in-flight beats are discarded and no output transfer occurs in the reset cycle.
- Arithmetic wraps modulo 2^WIDTH. No saturation.

## Configuration
- ADDER_FLAGS_EN defined: carry, overflow, zero are computed and registered as above.
- ADDER_FLAGS_EN undefined: flag logic and its registers are omitted; carry, overflow, zero are tied to 0. The result path and timing are unchanged.

## Test plan
- Reset: hold rst 2 cycles -> out_valid=0, result=0, flags=0, in_ready=1 in the cycle after reset.
- Add wrap: a=0xFFFFFFFF, b=0x00000001, sub=0, cin=0, out_ready=1 -> exactly 2 cycles after accept: result=0x00000000, carry=1, zero=1, overflow=0.
- Subtract with borrow: a=5, b=7, sub=1 -> result=0xFFFFFFFE, carry=0, overflow=0. Signed overflow: a=0x7FFFFFFF, b=1, sub=0 -> result=0x80000000, overflow=1, carry=0.
- Back-pressure: out_ready=0, present beats 1+1, 2+2, 3+3 on consecutive cycles -> first two accepted and in_ready=0 on the third. Raise out_ready -> results 2, 4, 6 in order, one per cycle, none lost.
- Carry across all groups: a=0x0FFFFFFF, b=0, cin=1 -> result=0x10000000, verifying the G/P chain through 7 groups. Also run random a/b/sub/cin for 10k beats against a reference model.
- Reset mid-flight: both stages valid, assert rst one cycle -> next cycle out_valid=0, and no stale result ever appears. Repeat with ADDER_FLAGS_EN undefined -> flags remain 0 and results match.
